// File: rtl/pmesh_pkg.sv
// Shared P-Mesh definitions: store size codes, header field positions,
// message types and the packetizer FSM state encoding.
package pmesh_pkg;

  // Store size codes; strb2mask emits pieces using the same encoding.
  localparam logic [2:0] SIZE_1B = 3'b001;
  localparam logic [2:0] SIZE_2B = 3'b010;
  localparam logic [2:0] SIZE_4B = 3'b011;
  localparam logic [2:0] SIZE_8B = 3'b100;

  // Header flit 0 field positions (LSB of each field).
  localparam int HDR_CHIPID_LSB = 50;
  localparam int HDR_X_LSB      = 42;
  localparam int HDR_Y_LSB      = 34;
  localparam int HDR_LEN_LSB    = 22;
  localparam int HDR_MSG_LSB    = 14;
  localparam int HDR_MSHR_LSB   = 6;

  // Three flits follow header flit 0 (HDR1, HDR2, DATA).
  localparam logic [7:0] HDR_PAYLOAD_LEN = 8'd3;

  // Message type codes.
  localparam logic [7:0] MSG_STORE_REQ = 8'd20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_HDR2,
    ST_DATA
  } state_e;

  // A piece is legal when its size code is known and the offset is
  // naturally aligned to that size.
  function automatic logic size_legal(input logic [2:0] size, input logic [2:0] off);
    case (size)
      SIZE_1B: return 1'b1;
      SIZE_2B: return (off[0] == 1'b0);
      SIZE_4B: return (off[1:0] == 2'b00);
      SIZE_8B: return (off == 3'b000);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pmesh_store_data_repl.sv
// Selects the lane group addressed by (size, offset) from a 64-bit word and
// replicates it across all 64 bits, as P-Mesh expects for sub-word data.
module pmesh_store_data_repl
  import pmesh_pkg::*;
(
  input  logic [63:0] wdata_i,
  input  logic [2:0]  size_i,
  input  logic [2:0]  offset_i,
  output logic [63:0] data_o
);

  // Addressed lanes moved down to bit 0; only the low 32 bits are needed
  // because 8-byte pieces bypass the shift entirely.
  logic [31:0] shifted;
  assign shifted = 32'(wdata_i >> {offset_i, 3'b000});

  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    logic [7:0] lane_b;

    // Each output byte takes the matching byte of the replicated group.
    always_comb begin
      lane_b = 8'h00;
      case (size_i)
        SIZE_1B: lane_b = shifted[7:0];
        SIZE_2B: lane_b = shifted[(gi % 2) * 8 +: 8];
        SIZE_4B: lane_b = shifted[(gi % 4) * 8 +: 8];
        SIZE_8B: lane_b = wdata_i[gi * 8 +: 8];
        default: lane_b = 8'h00;
      endcase
    end

    assign data_o[gi * 8 +: 8] = lane_b;
  end

endmodule

// File: rtl/pmesh_store_packetizer.sv
// Turns aligned store pieces from strb2mask into 4-flit P-Mesh store
// requests (HDR0, HDR1, HDR2, DATA) with a per-packet MSHR id.
module pmesh_store_packetizer
  import pmesh_pkg::*;
#(
  parameter int         ADDR_W      = 40,   // must lie in 4..64
  parameter logic [13:0] DEST_CHIPID = 14'd0,
  parameter logic [7:0]  DEST_X      = 8'd0,
  parameter logic [7:0]  DEST_Y      = 8'd0,
  parameter logic [7:0]  MSG_STORE   = MSG_STORE_REQ
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data_size,
  input  logic [2:0]        in_addr,
  input  logic [ADDR_W-1:0] in_base_addr,
  input  logic [63:0]       in_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       out_flit,
  output logic              err
);

  state_e              state_q, state_d;
  logic [2:0]          size_q;
  logic [2:0]          off_q;
  logic [ADDR_W-4:0]   base_q;
  logic [63:0]         wdata_q;
  logic [7:0]          mshr_q;
  logic                err_q;

  logic                in_hs;
  logic                piece_ok;
  logic [63:0]         repl_data;
  logic [63:0]         hdr0_flit;
  logic [63:0]         hdr1_flit;

  // Size code upper bits and the word address byte bits carry no meaning.
  logic                unused_bits;
  assign unused_bits = ^{in_data_size[7:3], in_base_addr[2:0]};

  // A new piece may enter while idle, or as the DATA flit leaves so that
  // packets stream back to back.
  assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DATA) & out_ready);
  assign in_hs     = in_valid & in_ready;
  assign piece_ok  = size_legal(in_data_size[2:0], in_addr);
  assign out_valid = (state_q != ST_IDLE);
  assign err       = err_q;

  // Next-state: each flit state waits for the NoC to accept its flit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_hs && piece_ok) state_d = ST_HDR0;
      ST_HDR0: if (out_ready) state_d = ST_HDR1;
      ST_HDR1: if (out_ready) state_d = ST_HDR2;
      ST_HDR2: if (out_ready) state_d = ST_DATA;
      ST_DATA: if (out_ready) state_d = (in_hs && piece_ok) ? ST_HDR0 : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, captured piece, MSHR counter and the one-cycle reject pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      size_q  <= '0;
      off_q   <= '0;
      base_q  <= '0;
      wdata_q <= '0;
      mshr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= in_hs & ~piece_ok;
      if (in_hs) begin
        size_q  <= in_data_size[2:0];
        off_q   <= in_addr;
        base_q  <= in_base_addr[ADDR_W-1:3];
        wdata_q <= in_wdata;
      end
      if ((state_q == ST_DATA) && out_ready) begin
        mshr_q <= mshr_q + 8'd1;
      end
    end
  end

  pmesh_store_data_repl u_repl (
    .wdata_i  (wdata_q),
    .size_i   (size_q),
    .offset_i (off_q),
    .data_o   (repl_data)
  );

  // Header flit 0 and the full byte address for header flit 1.
  always_comb begin
    hdr0_flit = '0;
    hdr0_flit[HDR_CHIPID_LSB +: 14] = DEST_CHIPID;
    hdr0_flit[HDR_X_LSB +: 8]       = DEST_X;
    hdr0_flit[HDR_Y_LSB +: 8]       = DEST_Y;
    hdr0_flit[HDR_LEN_LSB +: 8]     = HDR_PAYLOAD_LEN;
    hdr0_flit[HDR_MSG_LSB +: 8]     = MSG_STORE;
    hdr0_flit[HDR_MSHR_LSB +: 8]    = mshr_q;
    hdr1_flit = '0;
    hdr1_flit[ADDR_W-1:0] = {base_q, off_q};
  end

  // Flit mux; driven purely from registers, so it holds under backpressure.
  always_comb begin
    out_flit = '0;
    case (state_q)
      ST_HDR0: out_flit = hdr0_flit;
      ST_HDR1: out_flit = hdr1_flit;
      ST_HDR2: out_flit = {61'd0, size_q};
      ST_DATA: out_flit = repl_data;
      default: out_flit = '0;
    endcase
  end

endmodule

// File: tb/tb_pmesh_store_packetizer.sv
// Bench for pmesh_store_packetizer: directed and random pieces checked
// against a packet-level reference model (expected flit queue).
module tb_pmesh_store_packetizer;

  localparam int          ADDR_W = 40;
  localparam logic [13:0] CHIP   = 14'h2A5;
  localparam logic [7:0]  DX     = 8'h3C;
  localparam logic [7:0]  DY     = 8'hC3;
  localparam logic [7:0]  MSG    = 8'd20;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_data_size;
  logic [2:0]        in_addr;
  logic [ADDR_W-1:0] in_base_addr;
  logic [63:0]       in_wdata;
  logic              out_valid;
  logic              out_ready;
  logic [63:0]       out_flit;
  logic              err;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] obs_q[$];
  logic [63:0] exp_q[$];
  logic [7:0]  model_mshr = 8'd0;
  logic        accepted = 1'b0;

  pmesh_store_packetizer #(
    .ADDR_W      (ADDR_W),
    .DEST_CHIPID (CHIP),
    .DEST_X      (DX),
    .DEST_Y      (DY),
    .MSG_STORE   (MSG)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data_size (in_data_size),
    .in_addr      (in_addr),
    .in_base_addr (in_base_addr),
    .in_wdata     (in_wdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_flit     (out_flit),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---- reference model, written from the packet format rules ----
  function automatic int nbytes(input logic [2:0] sz);
    return 1 << (sz - 3'd1);
  endfunction

  function automatic logic model_legal(input logic [2:0] sz, input logic [2:0] a);
    if (sz < 3'd1 || sz > 3'd4) return 1'b0;
    return (int'(a) % nbytes(sz)) == 0;
  endfunction

  function automatic logic [63:0] hdr0_model(input logic [7:0] id);
    return (64'(CHIP) << 50) | (64'(DX) << 42) | (64'(DY) << 34) |
           (64'd3 << 22) | (64'(MSG) << 14) | (64'(id) << 6);
  endfunction

  function automatic logic [63:0] data_model(input logic [2:0] sz, input logic [2:0] a,
                                             input logic [63:0] w);
    int          nb;
    logic [63:0] lane;
    logic [63:0] r;
    nb   = nbytes(sz);
    lane = w >> (int'(a) * 8);
    if (nb < 8) lane = lane & ((64'd1 << (nb * 8)) - 64'd1);
    r = '0;
    for (int k = 0; k < 8 / nb; k++) r = r | (lane << (k * nb * 8));
    return r;
  endfunction

  task automatic model_accept();
    logic [2:0] sz;
    sz = in_data_size[2:0];
    if (model_legal(sz, in_addr)) begin
      exp_q.push_back(hdr0_model(model_mshr));
      exp_q.push_back(64'(in_base_addr & ~40'd7) | 64'(in_addr));
      exp_q.push_back(64'(sz));
      exp_q.push_back(data_model(sz, in_addr, in_wdata));
      model_mshr = model_mshr + 8'd1;
    end
  endtask

  // One clock: record handshakes just before the edge, then check that a
  // stalled flit is still presented unchanged afterwards.
  task automatic tick();
    logic        hs;
    logic        held;
    logic [63:0] hflit;
    hs    = 1'b0;
    held  = 1'b0;
    hflit = '0;
    #1;
    if (!rst) begin
      if (out_valid && out_ready) obs_q.push_back(out_flit);
      if (in_valid && in_ready) begin
        hs = 1'b1;
        model_accept();
      end
      if (out_valid && !out_ready) begin
        held  = 1'b1;
        hflit = out_flit;
      end
    end
    @(posedge clk);
    #1;
    accepted = hs;
    if (held && !rst) begin
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_flit", out_flit, hflit);
    end
  endtask

  task automatic compare_flits(input string tag);
    check($sformatf("%s_count", tag), 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("%s_flit%0d", tag, i), obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic set_piece(input logic [2:0] sz, input logic [2:0] a,
                           input logic [ADDR_W-1:0] base, input logic [63:0] w);
    in_data_size = {5'($urandom_range(0, 31)), sz};
    in_addr      = a;
    in_base_addr = base;
    in_wdata     = w;
  endtask

  task automatic rand_piece();
    logic [2:0] sz;
    logic [2:0] a;
    sz = 3'($urandom_range(1, 4));
    a  = 3'($urandom_range(0, 7)) & ~3'(nbytes(sz) - 1);
    set_piece(sz, a, 40'({$urandom(), $urandom()}), {$urandom(), $urandom()});
  endtask

  initial begin
    int          n;
    logic [63:0] dexp[4];
    logic [7:0]  saved_id;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    set_piece(3'd0, 3'd0, '0, '0);
    repeat (3) tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_flit", out_flit, 64'd0);
    check("rst_err", 64'(err), 64'd0);
    rst = 1'b0;
    out_ready = 1'b1;

    // 4-byte piece: flits on the four cycles after acceptance.
    set_piece(3'd3, 3'd4, 40'h1000, 64'h8877_6655_4433_2211);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    dexp[0] = hdr0_model(8'd0);
    dexp[1] = 64'h1004;
    dexp[2] = 64'd3;
    dexp[3] = 64'h8877_6655_8877_6655;
    check("p4_len", 64'(out_flit[29:22]), 64'd3);
    check("p4_mshr", 64'(out_flit[13:6]), 64'd0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("p4_valid%0d", k), 64'(out_valid), 64'd1);
      check($sformatf("p4_flit%0d", k), out_flit, dexp[k]);
      tick();
    end
    check("p4_idle", 64'(out_valid), 64'd0);
    compare_flits("p4");

    // Byte and halfword replication.
    set_piece(3'd1, 3'd6, 40'h2000, 64'h8877_6655_4433_2211);
    in_valid = 1'b1; tick(); in_valid = 1'b0;
    repeat (3) tick();
    check("p1_data", out_flit, 64'h7777_7777_7777_7777);
    tick();
    compare_flits("p1");
    set_piece(3'd2, 3'd2, 40'h2008, 64'h8877_6655_4433_2211);
    in_valid = 1'b1; tick(); in_valid = 1'b0;
    repeat (3) tick();
    check("p2_data", out_flit, 64'h4433_4433_4433_4433);
    tick();
    compare_flits("p2");

    // Back-to-back: three pieces, twelve consecutive flits.
    rand_piece(); in_valid = 1'b1; tick();
    n = 1; rand_piece();
    for (int c = 0; c < 12; c++) begin
      check($sformatf("b2b_valid%0d", c), 64'(out_valid), 64'd1);
      check($sformatf("b2b_ready%0d", c), 64'(in_ready), 64'((c % 4) == 3));
      tick();
      if (accepted) begin
        n++;
        if (n < 3) rand_piece(); else in_valid = 1'b0;
      end
    end
    check("b2b_pieces", 64'(n), 64'd3);
    check("b2b_idle", 64'(out_valid), 64'd0);
    compare_flits("b2b");

    // Backpressure: out_ready alternates every cycle.
    n = 0; rand_piece(); in_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      out_ready = ((c % 2) == 0);
      tick();
      if (accepted) begin
        n++;
        if (n < 2) rand_piece(); else in_valid = 1'b0;
      end
    end
    out_ready = 1'b1;
    check("bp_pieces", 64'(n), 64'd2);
    check("bp_idle", 64'(out_valid), 64'd0);
    compare_flits("bp");

    // Illegal pieces: misaligned halfword, then unknown size code.
    saved_id = model_mshr;
    set_piece(3'd2, 3'd1, 40'h3000, 64'h1111_2222_3333_4444);
    in_valid = 1'b1; tick();
    set_piece(3'd7, 3'd0, 40'h3008, 64'h5555_6666_7777_8888);
    check("ill1_err", 64'(err), 64'd1);
    check("ill1_in_ready", 64'(in_ready), 64'd1);
    check("ill1_out_valid", 64'(out_valid), 64'd0);
    tick(); in_valid = 1'b0;
    check("ill2_err", 64'(err), 64'd1);
    check("ill2_out_valid", 64'(out_valid), 64'd0);
    tick();
    check("ill_err_end", 64'(err), 64'd0);
    check("ill_out_valid_end", 64'(out_valid), 64'd0);
    compare_flits("ill");
    rand_piece(); in_valid = 1'b1; tick(); in_valid = 1'b0;
    check("ill_next_mshr", 64'(out_flit[13:6]), 64'(saved_id));
    repeat (4) tick();
    compare_flits("ill_next");

    // Long back-to-back run that carries the MSHR id through 255 -> 0.
    n = 0; rand_piece(); in_valid = 1'b1;
    for (int c = 0; c < 1100 && n < 250; c++) begin
      tick();
      if (accepted) begin
        n++;
        if (n < 250) rand_piece(); else in_valid = 1'b0;
      end
    end
    check("wrap_pieces", 64'(n), 64'd250);
    repeat (5) tick();
    compare_flits("wrap");

    // Reset while HDR1 is on the wire abandons the packet.
    rand_piece(); in_valid = 1'b1; tick(); in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    rst = 1'b1;
    tick();
    check("mrst_out_valid", 64'(out_valid), 64'd0);
    check("mrst_in_ready", 64'(in_ready), 64'd1);
    check("mrst_out_flit", out_flit, 64'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    obs_q.delete(); exp_q.delete();
    model_mshr = 8'd0;
    rand_piece(); in_valid = 1'b1; tick(); in_valid = 1'b0;
    check("post_rst_valid", 64'(out_valid), 64'd1);
    check("post_rst_mshr", 64'(out_flit[13:6]), 64'd0);
    check("post_rst_hdr0", out_flit, hdr0_model(8'd0));
    repeat (4) tick();
    compare_flits("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
